tristate_bus_arbiter: RTL and testbench
=======================================

Name: tristate_bus_arbiter

Overview:
- Round-robin arbiter that shares one tristate bus between N requesters.
- Each requester drives the bus through its own tristate buffer (data, enable, output).
- Issues one-hot grants and buffer enables, and inserts a turnaround gap between owners so that no two buffers ever drive at once.
- Forces release after a maximum hold time. Sits between the requesting agents and the bank of bus buffers.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive GRANT cycles for one owner (≥1).
- TURNAROUND, 1, idle cycles with all enables low between owners (0..7).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  level request per requester; held while the requester wants the bus.
- gnt  out  N  one-hot grant, registered.
- en  out  N  tristate buffer enables, registered, always equal to gnt.
- owner  out  clog2(N)  index of the current owner; valid only when busy=1.
- busy  out  1  high when some gnt bit is set.
- bus_float  out  1  high when no enable is asserted (keeper/pull hint).
- timeout  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, gnt=0, en=0, owner=0, busy=0, bus_float=1, timeout=0, rr_ptr=N-1 (so requester 0 wins first), hold_cnt=0, turn_cnt=0.
- Reset mid-grant: all enables drop immediately, without waiting for a clock edge.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If req≠0 at an edge, pick the winner w = first set bit scanning rr_ptr+1, rr_ptr+2, … with modulo-N wrap.
  - Next state GRANT, gnt=en=onehot(w), owner=w, rr_ptr=w, hold_cnt=0.
  - Latency from a req sampled high to gnt high is 1 cycle.
  - If req=0, stay in IDLE.
- GRANT:
  - hold_cnt increments each cycle.
  - Release occurs when req[owner]=0 at an edge, or when hold_cnt=MAX_HOLD-1 (this is a timeout, regardless of other requests).
  - On release, gnt and en clear at that edge and timeout=1 for one cycle only if the release was forced.
  - A requester that keeps req high after a timeout re-enters arbitration at the lowest priority (rr_ptr already points at it).
- TURN (TURNAROUND>0):
  - All enables stay low for exactly TURNAROUND cycles; turn_cnt counts them.
  - At the final TURN edge, arbitrate exactly as in IDLE: a winner goes to GRANT, otherwise the state is IDLE.
- TURNAROUND=0: the release edge goes directly to IDLE. Consequently at least one cycle of en=0 always separates two owners.
- Invariants:
  - popcount(en) ≤ 1 on every cycle.
  - en == gnt.
  - busy == |gnt.
  - bus_float == ~busy.
- Simultaneous events:
  - req[owner] dropping on the same edge as the timeout counts as a normal release, so timeout=0.
  - req bits of non-owners are ignored during GRANT and TURN.
  - A req pulse shorter than one cycle between edges is never seen.
- Counters: hold_cnt has width clog2(MAX_HOLD)+1 and never wraps, because it is cleared on grant. turn_cnt has width 3.

Decomposition:
- Shared package contents:
  - state encoding typedef (IDLE=0, GRANT=1, TURN=2);
  - the clog2 width constant helper;
  - default N, MAX_HOLD and TURNAROUND constants.
- One sub-module, rr_pick:
  - purely combinational round-robin priority picker;
  - inputs req[N] and ptr; outputs a valid flag and the winner index.
- The FSM and counters stay in the top module.

Test Plan:
- Reset, then req=4'b0001 at cycle 2: gnt=en=0001 at cycle 3, owner=0, busy=1. Drop req: gnt=0 next edge, 1 TURN cycle, then IDLE with bus_float=1.
- req=4'b1111 held with MAX_HOLD=8 and TURNAROUND=1: grants rotate 0→1→2→3→0. Each owner holds 8 cycles with timeout pulsed once, and 1 dead cycle follows each grant. popcount(en) ≤ 1 every cycle.
- Owner 2 active and req[1] rises: req[2] falls after 3 cycles, then 1 TURN cycle, then gnt=0010. Request 1 is not preempted earlier.
- TURNAROUND=0, req=4'b0011: gnt sequence 0001, 0000, 0010. There is exactly one idle cycle between owners.
- Assert rst asynchronously mid-GRANT (owner 3, hold_cnt=5): gnt, en and busy go to 0 before the next edge. After release with req=4'b1000, requester 3 is granted again because rr_ptr was reset to 3.
- req[0] falls on the same edge hold_cnt reaches 7: release with timeout=0, then normal TURN.

Source files
------------

// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared definitions for the tristate bus arbiter: state encoding, default
// sizing constants and the index-width helper.
package tristate_bus_arbiter_pkg;

  localparam int DEF_N          = 4;
  localparam int DEF_MAX_HOLD   = 8;
  localparam int DEF_TURNAROUND = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  // Width needed to hold an index in 0..v-1, never less than one bit.
  function automatic int clog2_w(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Bundle of request/grant/enable signals between the arbiter, the requesting
// agents and the bank of tristate buffers.
//
// Handshake: req[i] is a level request that the agent holds for as long as it
// wants the bus. gnt[i] high means agent i owns the bus on this cycle and its
// buffer is enabled (en == gnt). The agent drops req[i] to give the bus back;
// the arbiter may also revoke the grant after MAX_HOLD cycles, flagged by a
// one-cycle timeout pulse. state is a debug copy of the arbiter FSM.
interface tristate_bus_arbiter_if import tristate_bus_arbiter_pkg::*; #(
  parameter int N = DEF_N
);
  localparam int OW = clog2_w(N);

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [N-1:0]  en;
  logic [OW-1:0] owner;
  logic          busy;
  logic          bus_float;
  logic          timeout;
  logic [1:0]    state;

  modport master (
    input  req,
    output gnt, en, owner, busy, bus_float, timeout, state
  );

  modport slave (
    output req,
    input  gnt, en, owner, busy, bus_float, timeout, state
  );

endinterface

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: the winner is the first set request
// found scanning ptr+1, ptr+2, ... with wrap modulo N.
module tristate_bus_arbiter_rr_pick import tristate_bus_arbiter_pkg::*; #(
  parameter int N  = DEF_N,
  parameter int OW = clog2_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [OW-1:0] ptr,
  output logic          valid,
  output logic [OW-1:0] winner
);

  logic [OW-1:0] idx;

  // Scan from the farthest offset down to ptr+1 so the nearest hit wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = N; k >= 1; k--) begin
      idx = OW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter sharing one tristate bus between N requesters. Grants
// are one-hot and double as buffer enables; a turnaround gap separates owners
// and a hold limit forces release of a greedy owner.
module tristate_bus_arbiter import tristate_bus_arbiter_pkg::*; #(
  parameter int N          = DEF_N,
  parameter int MAX_HOLD   = DEF_MAX_HOLD,
  parameter int TURNAROUND = DEF_TURNAROUND
) (
  input logic                   clk,
  input logic                   rst,
  tristate_bus_arbiter_if.master bus
);

  localparam int OW = clog2_w(N);
  localparam int HW = clog2_w(MAX_HOLD) + 1;

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] GRANT = ST_GRANT;
  localparam logic [1:0] TURN  = ST_TURN;

  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  // Unused when TURNAROUND is 0, since release then goes straight to IDLE.
  localparam logic [2:0]    TURN_LAST = (TURNAROUND == 0) ? 3'd0 : 3'(TURNAROUND - 1);

  logic [1:0]    state, state_d;
  logic [N-1:0]  gnt, gnt_d;
  logic [OW-1:0] owner, owner_d;
  logic [OW-1:0] rr_ptr, rr_ptr_d;
  logic [HW-1:0] hold_cnt, hold_cnt_d;
  logic [2:0]    turn_cnt, turn_cnt_d;
  logic          timeout, timeout_d;

  logic          pick_valid;
  logic [OW-1:0] pick_idx;

  tristate_bus_arbiter_rr_pick #(.N(N), .OW(OW)) u_pick (
    .req    (bus.req),
    .ptr    (rr_ptr),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  // Next-state logic: arbitration from IDLE or the last TURN cycle,
  // release on request drop (normal) or hold limit (forced).
  always_comb begin
    state_d    = state;
    gnt_d      = gnt;
    owner_d    = owner;
    rr_ptr_d   = rr_ptr;
    hold_cnt_d = hold_cnt;
    turn_cnt_d = turn_cnt;
    timeout_d  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_d    = GRANT;
          gnt_d      = N'(1) << pick_idx;
          owner_d    = pick_idx;
          rr_ptr_d   = pick_idx;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        // A request drop wins over the hold limit, so a coincident drop is
        // a normal release without a timeout pulse.
        if (!bus.req[owner] || (hold_cnt == HOLD_LAST)) begin
          gnt_d      = '0;
          timeout_d  = bus.req[owner];
          turn_cnt_d = '0;
          state_d    = (TURNAROUND == 0) ? IDLE : TURN;
        end else begin
          hold_cnt_d = hold_cnt + HW'(1);
        end
      end
      TURN: begin
        if (turn_cnt == TURN_LAST) begin
          if (pick_valid) begin
            state_d    = GRANT;
            gnt_d      = N'(1) << pick_idx;
            owner_d    = pick_idx;
            rr_ptr_d   = pick_idx;
            hold_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          turn_cnt_d = turn_cnt + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers; the asynchronous reset drops every enable immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      rr_ptr   <= OW'(N - 1);
      hold_cnt <= '0;
      turn_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      owner    <= owner_d;
      rr_ptr   <= rr_ptr_d;
      hold_cnt <= hold_cnt_d;
      turn_cnt <= turn_cnt_d;
      timeout  <= timeout_d;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.en        = gnt;
  assign bus.owner     = owner;
  assign bus.busy      = |gnt;
  assign bus.bus_float = ~|gnt;
  assign bus.timeout   = timeout;
  assign bus.state     = state;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed testbench for tristate_bus_arbiter: one default instance
// (MAX_HOLD=8, TURNAROUND=1) and one with TURNAROUND=0.
module tb_tristate_bus_arbiter;
  import tristate_bus_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  tristate_bus_arbiter_if #(.N(4)) bus ();
  tristate_bus_arbiter_if #(.N(4)) bus0 ();

  tristate_bus_arbiter #(.N(4), .MAX_HOLD(8), .TURNAROUND(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  tristate_bus_arbiter #(.N(4), .MAX_HOLD(8), .TURNAROUND(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus0.req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
    total++; if (bus.en !== 4'b0000) begin bad++; $display("FAIL reset_en got=%b exp=0000", bus.en); end
    total++; if (bus.owner !== 2'd0) begin bad++; $display("FAIL reset_owner got=%0d exp=0", bus.owner); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.bus_float !== 1'b1) begin bad++; $display("FAIL reset_float got=%b exp=1", bus.bus_float); end
    total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", bus.timeout); end
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bus.req = 4'b0001;
    tick();
    total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b exp=0001", bus.gnt); end
    total++; if (bus.en !== 4'b0001) begin bad++; $display("FAIL single_en got=%b exp=0001", bus.en); end
    total++; if (bus.owner !== 2'd0) begin bad++; $display("FAIL single_owner got=%0d exp=0", bus.owner); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    total++; if (bus.bus_float !== 1'b0) begin bad++; $display("FAIL single_float got=%b exp=0", bus.bus_float); end
    bus.req = 4'b0000;
    tick();
    total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL single_rel_gnt got=%b exp=0000", bus.gnt); end
    total++; if (bus.state !== 2'd2) begin bad++; $display("FAIL single_turn_state got=%0d exp=2", bus.state); end
    total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL single_rel_timeout got=%b exp=0", bus.timeout); end
    tick();
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL single_idle_state got=%0d exp=0", bus.state); end
    total++; if (bus.bus_float !== 1'b1) begin bad++; $display("FAIL single_idle_float got=%b exp=1", bus.bus_float); end
  endtask

  task automatic test_rotation();
    logic [3:0] e;
    int owners [5];
    owners = '{0, 1, 2, 3, 0};
    do_reset();
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      e = 4'b0001 << owners[g];
      for (int c = 0; c < 8; c++) begin
        tick();
        total++; if (bus.gnt !== e) begin bad++; $display("FAIL rot_gnt g=%0d c=%0d got=%b exp=%b", g, c, bus.gnt, e); end
        total++; if (bus.en !== e) begin bad++; $display("FAIL rot_en g=%0d c=%0d got=%b exp=%b", g, c, bus.en, e); end
        total++; if ($countones(bus.en) > 1) begin bad++; $display("FAIL rot_onehot g=%0d c=%0d got=%b exp=at_most_one", g, c, bus.en); end
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL rot_timeout_low g=%0d c=%0d got=%b exp=0", g, c, bus.timeout); end
      end
      tick();
      total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL rot_gap_gnt g=%0d got=%b exp=0000", g, bus.gnt); end
      total++; if (bus.timeout !== 1'b1) begin bad++; $display("FAIL rot_timeout_pulse g=%0d got=%b exp=1", g, bus.timeout); end
      total++; if (bus.bus_float !== 1'b1) begin bad++; $display("FAIL rot_gap_float g=%0d got=%b exp=1", g, bus.bus_float); end
    end
    bus.req = 4'b0000;
    tick();
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL rot_end_state got=%0d exp=0", bus.state); end
  endtask

  task automatic test_no_preempt();
    do_reset();
    bus.req = 4'b0100;
    tick();
    total++; if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL np_first_gnt got=%b exp=0100", bus.gnt); end
    total++; if (bus.owner !== 2'd2) begin bad++; $display("FAIL np_first_owner got=%0d exp=2", bus.owner); end
    bus.req = 4'b0110;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL np_hold_gnt c=%0d got=%b exp=0100", c, bus.gnt); end
    end
    bus.req = 4'b0010;
    tick();
    total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL np_turn_gnt got=%b exp=0000", bus.gnt); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL np_turn_busy got=%b exp=0", bus.busy); end
    tick();
    total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL np_second_gnt got=%b exp=0010", bus.gnt); end
    total++; if (bus.owner !== 2'd1) begin bad++; $display("FAIL np_second_owner got=%0d exp=1", bus.owner); end
    bus.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_zero_turnaround();
    do_reset();
    bus0.req = 4'b0011;
    tick();
    total++; if (bus0.gnt !== 4'b0001) begin bad++; $display("FAIL ta0_gnt_a got=%b exp=0001", bus0.gnt); end
    bus0.req = 4'b0010;
    tick();
    total++; if (bus0.gnt !== 4'b0000) begin bad++; $display("FAIL ta0_gap_gnt got=%b exp=0000", bus0.gnt); end
    total++; if (bus0.state !== 2'd0) begin bad++; $display("FAIL ta0_gap_state got=%0d exp=0", bus0.state); end
    tick();
    total++; if (bus0.gnt !== 4'b0010) begin bad++; $display("FAIL ta0_gnt_b got=%b exp=0010", bus0.gnt); end
    total++; if (bus0.owner !== 2'd1) begin bad++; $display("FAIL ta0_owner_b got=%0d exp=1", bus0.owner); end
    bus0.req = 4'b0000;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req = 4'b1000;
    tick();
    total++; if (bus.gnt !== 4'b1000) begin bad++; $display("FAIL ar_gnt got=%b exp=1000", bus.gnt); end
    for (int c = 0; c < 5; c++) tick();
    total++; if (bus.owner !== 2'd3) begin bad++; $display("FAIL ar_owner_pre got=%0d exp=3", bus.owner); end
    rst = 1'b1;
    #1;
    total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL ar_gnt_drop got=%b exp=0000", bus.gnt); end
    total++; if (bus.en !== 4'b0000) begin bad++; $display("FAIL ar_en_drop got=%b exp=0000", bus.en); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ar_busy_drop got=%b exp=0", bus.busy); end
    #1;
    rst = 1'b0;
    tick();
    total++; if (bus.gnt !== 4'b1000) begin bad++; $display("FAIL ar_regrant_gnt got=%b exp=1000", bus.gnt); end
    total++; if (bus.owner !== 2'd3) begin bad++; $display("FAIL ar_regrant_owner got=%0d exp=3", bus.owner); end
    bus.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_drop_at_limit();
    do_reset();
    bus.req = 4'b0001;
    tick();
    total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL lim_gnt0 got=%b exp=0001", bus.gnt); end
    for (int c = 1; c < 8; c++) begin
      tick();
      total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL lim_hold c=%0d got=%b exp=0001", c, bus.gnt); end
    end
    bus.req = 4'b0000;
    tick();
    total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL lim_rel_gnt got=%b exp=0000", bus.gnt); end
    total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL lim_timeout got=%b exp=0", bus.timeout); end
    total++; if (bus.state !== 2'd2) begin bad++; $display("FAIL lim_turn_state got=%0d exp=2", bus.state); end
    tick();
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL lim_idle_state got=%0d exp=0", bus.state); end
    total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL lim_idle_timeout got=%b exp=0", bus.timeout); end
  endtask

  // Test sequence and final report
  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus0.req = 4'b0000;
    test_reset();
    test_single();
    test_rotation();
    test_no_preempt();
    test_zero_turnaround();
    test_async_reset();
    test_drop_at_limit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
